// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Pushbutton conditioner. Every key is synchronised, debounced
//                and turned into a clean level plus one-cycle press/release
//                pulses for the counter/display datapath.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1         system clock (50 MHz)
//    reset_n      in   1         asynchronous, active-low reset
//    key_in       in   NUM_KEYS  raw buttons, active-low, asynchronous to clk
//    key_level    out  NUM_KEYS  debounced state, 1 = pressed
//    key_press    out  NUM_KEYS  one-cycle pulse on an accepted press
//    key_release  out  NUM_KEYS  one-cycle pulse on an accepted release
//
//  Parameters
//    NUM_KEYS         number of independent keys
//    DEBOUNCE_CYCLES  consecutive disagreeing samples needed to accept a
//                     change (2 .. 2^CNT_W-1)
//    CNT_W            debounce counter width
//    REPEAT_DELAY     hold time before the first auto-repeat press pulse
//    REPEAT_PERIOD    spacing of the following auto-repeat pulses
//
//  Build option
//    KEY_REPEAT_EN    when defined, a key held in the PRESSED state emits
//                     extra key_press pulses (auto-repeat). When undefined
//                     exactly one key_press is produced per accepted press.
// ============================================================================
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    // ------------------------------------------------------------------------
    // Per-key debounce state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    // The counter only ever reaches this value, so it can never wrap.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                              : REPEAT_PERIOD;
    localparam int RPT_W     = $clog2(c_RPT_MAX + 1);

    localparam logic [RPT_W-1:0] c_RPT_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0] c_RPT_DELAY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] c_RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
`endif

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if ((DEBOUNCE_CYCLES < 2) ||
        (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
        $error("key_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Flops hold the raw (active-low) polarity so the
    // reset value of 1 means "released".
    // ------------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync_meta_q;
    logic [NUM_KEYS-1:0] sync_q;
    logic [NUM_KEYS-1:0] pressed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= '1;
            sync_q      <= '1;
        end else begin
            sync_meta_q <= key_in;
            sync_q      <= sync_meta_q;
        end
    end

    // Synchronised and inverted: 1 = pressed.
    assign pressed_d = ~sync_q;

    // ------------------------------------------------------------------------
    // Per-key debounce FSM with registered outputs
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key

        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             s_d;

        assign s_d = pressed_d[k];

`ifdef KEY_REPEAT_EN
        // Auto-repeat: rpt_cnt_q counts cycles spent steadily in PRESSED.
        // The first target is REPEAT_DELAY; after the first pulse
        // (rpt_armed_q set) the target becomes REPEAT_PERIOD and the count
        // restarts after every pulse.
        logic [RPT_W-1:0] rpt_cnt_q;
        logic             rpt_armed_q;
        logic [RPT_W-1:0] rpt_next_d;
        logic [RPT_W-1:0] rpt_tgt_d;
        logic             rpt_fire_d;

        assign rpt_next_d = rpt_cnt_q + c_RPT_ONE;
        assign rpt_tgt_d  = rpt_armed_q ? c_RPT_PERIOD : c_RPT_DELAY;
        assign rpt_fire_d = (rpt_next_d == rpt_tgt_d);
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q     <= ST_RELEASED;
                cnt_q       <= '0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                rpt_cnt_q   <= '0;
                rpt_armed_q <= 1'b0;
`endif
            end else begin
                // Pulses last one cycle unless re-asserted below.
                press_q   <= 1'b0;
                release_q <= 1'b0;

                case (state_q)
                    ST_RELEASED: begin
                        if (s_d) begin
                            state_q <= ST_PRESS_PEND;
                            cnt_q   <= c_CNT_ONE;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end

                    ST_PRESS_PEND: begin
                        if (!s_d) begin
                            // Bounce: fall back without any pulse.
                            state_q <= ST_RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_q == c_CNT_LAST) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + c_CNT_ONE;
                        end
                    end

                    ST_PRESSED: begin
                        if (!s_d) begin
                            state_q <= ST_RELEASE_PEND;
                            cnt_q   <= c_CNT_ONE;
                        end
`ifdef KEY_REPEAT_EN
                        else if (rpt_fire_d) begin
                            press_q     <= 1'b1;
                            rpt_cnt_q   <= '0;
                            rpt_armed_q <= 1'b1;
                        end else begin
                            rpt_cnt_q   <= rpt_next_d;
                        end
`endif
                    end

                    ST_RELEASE_PEND: begin
                        // Repeat counter deliberately holds in this state.
                        if (s_d) begin
                            // Release glitch: back to PRESSED, no pulse.
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q == c_CNT_LAST) begin
                            state_q     <= ST_RELEASED;
                            cnt_q       <= '0;
                            level_q     <= 1'b0;
                            release_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
                            rpt_cnt_q   <= '0;
                            rpt_armed_q <= 1'b0;
`endif
                        end else begin
                            cnt_q   <= cnt_q + c_CNT_ONE;
                        end
                    end

                    default: begin
                        state_q     <= ST_RELEASED;
                        cnt_q       <= '0;
                        level_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
                        rpt_cnt_q   <= '0;
                        rpt_armed_q <= 1'b0;
`endif
                    end
                endcase
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Self-checking bench for key_conditioner. A sliding-window
//                reference model (a key change is accepted once the last
//                DEBOUNCE_CYCLES synchronised samples all disagree with the
//                current level) predicts every output, alongside directed
//                edge-exact checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (20),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // hist[k][0] = newest pressed-sample (taken at this edge), hist[k][i] = i edges older.
    logic [DB+1:0] hist [NK];
    logic [NK-1:0] m_level, m_press, m_rel;
    int            held [NK];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            hist[k] = '0;
            held[k] = 0;
        end
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
    endtask

    function automatic bit repeat_due(input int h);
        if (h == RD) return 1'b1;
        if ((h > RD) && (((h - RD) % RP) == 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < NK; k++) begin
            logic [DB+1:0] h;
            logic [DB-1:0] win;
            h       = {hist[k][DB:0], ~key_in[k]};
            hist[k] = h;
            // Debounce sees samples two edges late (synchroniser).
            win     = h[DB+1:2];
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            if (!m_level[k] && (&win)) begin
                m_level[k] = 1'b1;
                m_press[k] = 1'b1;
                held[k]    = 0;
            end else if (m_level[k] && !(|win)) begin
                m_level[k] = 1'b0;
                m_rel[k]   = 1'b1;
                held[k]    = 0;
            end else if (m_level[k] && h[2] && h[3]) begin
                // Steadily pressed for this cycle: auto-repeat time advances.
                held[k]++;
                if (RPT_ON && repeat_due(held[k])) m_press[k] = 1'b1;
            end
        end
    endtask

    // One clock edge; model follows the DUT, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        key_in  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                bad++;
                $display("FAIL reset_hold: level=%b press=%b release=%b want all 0",
                         key_level, key_press, key_release);
            end
        end
        key_in  = 4'b1111;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                bad++;
                $display("FAIL reset_release: level=%b press=%b release=%b want all 0",
                         key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_clean_press();
        key_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ((key_level[0] !== (e >= 6)) || (key_press[0] !== (e == 6)) ||
                (key_release !== 4'b0000)) begin
                bad++;
                $display("FAIL clean_press edge %0d: level0=%b press0=%b release=%b want level0=%b press0=%b release=0000",
                         e, key_level[0], key_press[0], key_release, (e >= 6), (e == 6));
            end
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL clean_press_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         e, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] pat;
        pat = 16'b1111_1111_0001_1000; // bit i = raw key_in[1] for tick i
        for (int i = 0; i < 16; i++) begin
            key_in[1] = pat[i];
            tick();
            total++;
            if ((key_level[1] !== 1'b0) || (key_press[1] !== 1'b0) || (key_release[1] !== 1'b0)) begin
                bad++;
                $display("FAIL bounce tick %0d: level1=%b press1=%b release1=%b want 0/0/0",
                         i, key_level[1], key_press[1], key_release[1]);
            end
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL bounce_model tick %0d: got %b/%b/%b want %b/%b/%b",
                         i, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    task automatic test_release();
        // Two-cycle release glitch must be swallowed.
        for (int i = 0; i < 10; i++) begin
            key_in[0] = (i < 2) ? 1'b1 : 1'b0;
            tick();
            total++;
            if ((key_level[0] !== 1'b1) || (key_release[0] !== 1'b0)) begin
                bad++;
                $display("FAIL release_glitch tick %0d: level0=%b release0=%b want 1/0",
                         i, key_level[0], key_release[0]);
            end
        end
        key_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ((key_level[0] !== (e < 6)) || (key_release[0] !== (e == 6))) begin
                bad++;
                $display("FAIL release edge %0d: level0=%b release0=%b want %b/%b",
                         e, key_level[0], key_release[0], (e < 6), (e == 6));
            end
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL release_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         e, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    task automatic test_independence();
        key_in = 4'b0011;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ((key_press[3:2] !== ((e == 6) ? 2'b11 : 2'b00)) ||
                (key_level[3:2] !== ((e >= 6) ? 2'b11 : 2'b00))) begin
                bad++;
                $display("FAIL independence edge %0d: press32=%b level32=%b want %b/%b",
                         e, key_press[3:2], key_level[3:2], (e == 6) ? 2'b11 : 2'b00,
                         (e >= 6) ? 2'b11 : 2'b00);
            end
        end
        key_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL independence_model tick %0d: got %b/%b/%b want %b/%b/%b",
                         i, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        key_in = 4'b1110;
        for (int i = 0; i < 8; i++) tick();
        key_in[1] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        // Asynchronous assertion: outputs must clear without a clock edge.
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({key_level, key_press, key_release} !== 12'h000) begin
            bad++;
            $display("FAIL reset_async: level=%b press=%b release=%b want all 0",
                     key_level, key_press, key_release);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total++;
            if ((key_level[1:0] !== ((e >= 6) ? 2'b11 : 2'b00)) ||
                (key_press[1:0] !== ((e == 6) ? 2'b11 : 2'b00))) begin
                bad++;
                $display("FAIL reset_restart edge %0d: level10=%b press10=%b want %b/%b",
                         e, key_level[1:0], key_press[1:0], (e >= 6) ? 2'b11 : 2'b00,
                         (e == 6) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_repeat();
        key_in = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        key_in[0] = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            int  off;
            bit  want;
            tick();
            off  = e - 6;
            want = (off == 0) ||
                   (RPT_ON && (off >= RD) && (((off - RD) % RP) == 0));
            total++;
            if (key_press[0] !== want) begin
                bad++;
                $display("FAIL repeat edge %0d (offset %0d): press0=%b want %b",
                         e, off, key_press[0], want);
            end
        end
        key_in = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL repeat_model tick %0d: got %b/%b/%b want %b/%b/%b",
                         i, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            int prob;
            prob = (c < 1000) ? 3 : ((c < 2000) ? 8 : 30);
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(prob - 1, 0) == 0) key_in[k] = ~key_in[k];
            end
            if ($urandom_range(499, 0) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                total++;
                if ({key_level, key_press, key_release} !== 12'h000) begin
                    bad++;
                    $display("FAIL random_reset cycle %0d: level=%b press=%b release=%b want all 0",
                             c, key_level, key_press, key_release);
                end
            end
            tick();
            reset_n = 1'b1;
            total++;
            if ({key_level, key_press, key_release} !== {m_level, m_press, m_rel}) begin
                bad++;
                $display("FAIL random cycle %0d: got %b/%b/%b want %b/%b/%b",
                         c, key_level, key_press, key_release, m_level, m_press, m_rel);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_in  = 4'b0000;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_independence();
        test_reset_mid_pending();
        test_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
